bird_physics: RTL and testbench

BIRD_PHYSICS -- requirements
Module: bird_physics

---
 rtl/bird_physics.sv | 148 ++++++++++++++
 tb/tb_bird_physics.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bird_physics.sv
// Flappy-bird vertical physics: synchronised game tick and flap inputs drive a
// three-state game FSM with integer position/velocity integration.
module bird_physics #(
  parameter int unsigned Y_INIT   = 240,
  parameter int unsigned Y_MAX    = 464,
  parameter int          FLAP_VEL = -8,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned V_MAX    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_clk,
  input  logic       flap,
  output logic [9:0] bird_y,
  output logic [4:0] vel,
  output logic [1:0] state,
  output logic       game_over
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StDead = 2'd2
  } state_e;

  localparam logic        [9:0]  LpYInit  = 10'(Y_INIT);
  localparam logic signed [10:0] LpYMax   = 11'(Y_MAX);
  localparam logic signed [4:0]  LpFlap   = 5'(FLAP_VEL);
  localparam logic signed [6:0]  LpGrav   = 7'(GRAVITY);
  localparam logic signed [6:0]  LpVMax   = 7'(V_MAX);

  logic       r_tick_s1, r_tick_s2, r_tick_q;
  logic       r_flap_s1, r_flap_s2, r_flap_q;
  logic [1:0] r_prime;
  logic       r_armed;
  logic       w_tick_p, w_flap_p, w_flap_now;

  state_e            r_state, w_state_nxt;
  logic        [9:0] r_bird_y, w_bird_y_nxt;
  logic signed [4:0] r_vel, w_vel_nxt, w_vel_inc;
  logic              r_flap_pend, w_flap_pend_nxt;
  logic signed [6:0] w_vel_sum;
  logic signed [10:0] w_y_sum;

  // Ticks stay disarmed until the synchroniser has flushed and seen tick_clk
  // low, so a level already high at reset release never counts as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_s1 <= 1'b0;
      r_tick_s2 <= 1'b0;
      r_tick_q  <= 1'b0;
      r_flap_s1 <= 1'b0;
      r_flap_s2 <= 1'b0;
      r_flap_q  <= 1'b0;
      r_prime   <= 2'd0;
      r_armed   <= 1'b0;
    end else begin
      r_tick_s1 <= tick_clk;
      r_tick_s2 <= r_tick_s1;
      r_tick_q  <= r_tick_s2;
      r_flap_s1 <= flap;
      r_flap_s2 <= r_flap_s1;
      r_flap_q  <= r_flap_s2;
      r_prime   <= (r_prime == 2'd2) ? 2'd2 : r_prime + 2'd1;
      r_armed   <= r_armed | ((r_prime == 2'd2) & ~r_tick_s2);
    end
  end

  assign w_tick_p   = r_tick_s2 & ~r_tick_q & r_armed;
  assign w_flap_p   = r_flap_s2 & ~r_flap_q;
  assign w_flap_now = r_flap_pend | w_flap_p;

  assign w_vel_sum = {{2{r_vel[4]}}, r_vel} + LpGrav;
  assign w_vel_inc = (w_vel_sum > LpVMax) ? LpVMax[4:0] : w_vel_sum[4:0];
  assign w_y_sum   = {1'b0, r_bird_y} + {{6{r_vel[4]}}, r_vel};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_bird_y    <= LpYInit;
      r_vel       <= 5'sd0;
      r_flap_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bird_y    <= w_bird_y_nxt;
      r_vel       <= w_vel_nxt;
      r_flap_pend <= w_flap_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_bird_y_nxt    = r_bird_y;
    w_vel_nxt       = r_vel;
    w_flap_pend_nxt = r_flap_pend;
    case (r_state)
      StIdle: begin
        w_bird_y_nxt    = LpYInit;
        w_vel_nxt       = 5'sd0;
        w_flap_pend_nxt = 1'b0;
        if (w_flap_p) begin
          w_state_nxt = StPlay;
          w_vel_nxt   = LpFlap;
        end
      end
      StPlay: begin
        if (w_tick_p) begin
          w_flap_pend_nxt = 1'b0;
          if (w_y_sum[10]) begin
            w_bird_y_nxt = 10'd0;
            w_vel_nxt    = w_flap_now ? LpFlap : 5'sd0;
          end else if (w_y_sum >= LpYMax) begin
            w_bird_y_nxt = LpYMax[9:0];
            w_vel_nxt    = 5'sd0;
            w_state_nxt  = StDead;
          end else begin
            w_bird_y_nxt = w_y_sum[9:0];
            w_vel_nxt    = w_flap_now ? LpFlap : w_vel_inc;
          end
        end else if (w_flap_p) begin
          w_flap_pend_nxt = 1'b1;
        end
      end
      StDead: begin
        if (w_flap_p) begin
          w_state_nxt     = StIdle;
          w_bird_y_nxt    = LpYInit;
          w_vel_nxt       = 5'sd0;
          w_flap_pend_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt     = StIdle;
        w_bird_y_nxt    = LpYInit;
        w_vel_nxt       = 5'sd0;
        w_flap_pend_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    bird_y    = r_bird_y;
    vel       = r_vel;
    state     = r_state;
    game_over = (r_state == StDead);
  end

endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics: hand-computed trajectories for flap, gravity,
// ceiling, floor, restart and reset-while-tick-high behaviour.
module tb_bird_physics;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_clk = 1'b0;
  logic       flap = 1'b0;
  logic [9:0] bird_y;
  logic [4:0] vel;
  logic [1:0] state;
  logic       game_over;

  int n_cmp = 0;
  int n_fail = 0;

  bird_physics dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_clk  (tick_clk),
    .flap      (flap),
    .bird_y    (bird_y),
    .vel       (vel),
    .state     (state),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag, input int y, input int v, input int st);
    check({tag, ".y"}, int'(bird_y), y);
    check({tag, ".vel"}, int'($signed(vel)), v);
    check({tag, ".state"}, int'(state), st);
  endtask

  task automatic do_tick();
    tick_clk = 1'b1;
    repeat (6) @(posedge clk);
    tick_clk = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic do_flap();
    flap = 1'b1;
    repeat (4) @(posedge clk);
    flap = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_flap_tick();
    flap = 1'b1;
    tick_clk = 1'b1;
    repeat (6) @(posedge clk);
    flap = 1'b0;
    tick_clk = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 240, 0, 0);
    check("reset.go", int'(game_over), 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Ticks in IDLE do nothing
    do_tick();
    check_all("idle_tick", 240, 0, 0);

    // Start play and basic trajectory
    do_flap();
    check_all("start", 240, -8, 1);
    do_tick();
    check_all("tick1", 232, -7, 1);
    do_tick();
    check_all("tick2", 225, -6, 1);

    // Free fall to terminal velocity, then floor
    for (int i = 0; i < 37; i++) begin
      do_tick();
      check("fall.vel_le_max", ($signed(vel) <= 10) ? 1 : 0, 1);
    end
    check_all("fall39", 459, 10, 1);
    do_tick();
    check_all("floor", 464, 0, 2);
    check("floor.go", int'(game_over), 1);
    do_tick();
    check_all("dead_tick", 464, 0, 2);

    // Restart from DEAD, idle ticks ignored
    do_flap();
    check_all("restart", 240, 0, 0);
    check("restart.go", int'(game_over), 0);
    do_tick();
    check_all("restart_tick", 240, 0, 0);

    // Flap and tick together in IDLE: transition only
    do_flap_tick();
    check_all("idle_flap_tick", 240, -8, 1);

    // Climb to the ceiling: 19 flapped ticks, then 5 (coast, flap) pairs
    for (int i = 0; i < 19; i++) begin
      do_flap();
      do_tick();
    end
    check_all("climb19", 88, -8, 1);
    for (int i = 0; i < 5; i++) begin
      do_tick();
      do_flap();
      do_tick();
    end
    check_all("row13", 13, -8, 1);
    do_flap();
    do_tick();
    check_all("row5", 5, -8, 1);
    do_flap();
    do_tick();
    check_all("ceil1", 0, -8, 1);
    do_flap();
    do_tick();
    check_all("ceil2", 0, -8, 1);
    do_tick();
    check_all("ceil_stop0", 0, 0, 1);
    do_tick();
    check_all("ceil_stop1", 0, 1, 1);
    do_tick();
    check_all("ceil_stop2", 1, 2, 1);

    // Fall a little, then flap coincident with tick and double flap
    do_tick();
    do_tick();
    do_tick();
    do_tick();
    check_all("fall4", 15, 6, 1);
    do_flap_tick();
    check_all("same_cycle", 21, -8, 1);
    do_flap();
    do_flap();
    do_tick();
    check_all("double_flap", 13, -8, 1);
    do_tick();
    check_all("after_double", 5, -7, 1);

    // Reset while tick_clk high
    tick_clk = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_all("tick_high", 0, 0, 1);
    rst_n = 1'b0;
    #2;
    check_all("async_reset", 240, 0, 0);
    check("async_reset.go", int'(game_over), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_flap();
    repeat (10) @(posedge clk);
    #1;
    check_all("stale_high", 240, -8, 1);
    tick_clk = 1'b0;
    repeat (6) @(posedge clk);
    do_tick();
    check_all("first_real_tick", 232, -7, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
